// File: rtl/ysyx_2022040010_lsu_req_pkg.sv
// Shared definitions for the LSU request block: access sizes, FSM states,
// default response timeout and the alignment rule.
package ysyx_2022040010_lsu_req_pkg;

    typedef enum logic [1:0] {
        SzB = 2'd0,
        SzH = 2'd1,
        SzW = 2'd2,
        SzD = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } lsu_state_e;

    localparam int unsigned LsuTimeoutDefault = 255;

    // A sized access is misaligned when its address is not a multiple of its size.
    function automatic logic is_misaligned(lsu_size_e size, logic [2:0] off);
        logic mis;
        mis = 1'b0;
        unique case (size)
            SzB: mis = 1'b0;
            SzH: mis = off[0];
            SzW: mis = |off[1:0];
            SzD: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_2022040010_lsu_req_if.sv
// EX-side request and data-SRAM bus bundle of the LSU request block.
// master: the LSU itself; slave: the EX stage / SRAM / MEM stage around it.
interface ysyx_2022040010_lsu_req_if;

    logic        op_valid;
    logic        op_ready;
    logic        op_we;
    logic [1:0]  op_size;
    logic [63:0] op_addr;
    logic [63:0] op_wdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    logic [7:0]  dsram_sel;
    logic [63:0] dsram_rdata;
    logic        lsu_done;
    logic        misalign_err;
    logic        bus_err;
    logic        stall_req;

    modport master (
        input  op_valid, op_we, op_size, op_addr, op_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output op_ready,
        output mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output dsram_sel, dsram_rdata, lsu_done, misalign_err, bus_err, stall_req
    );

    modport slave (
        output op_valid, op_we, op_size, op_addr, op_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  op_ready,
        input  mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  dsram_sel, dsram_rdata, lsu_done, misalign_err, bus_err, stall_req
    );

endinterface

// File: rtl/ysyx_2022040010_lsu_fmt.sv
// Byte-select and store-data lane replication for one sized access.
module ysyx_2022040010_lsu_fmt
    import ysyx_2022040010_lsu_req_pkg::*;
(
    input  lsu_size_e   size_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] wdata_i,
    output logic [7:0]  sel_o,
    output logic [63:0] wdata_o
);

    // Shift the size mask to the byte offset and copy the low lanes across the doubleword.
    always_comb begin
        sel_o   = 8'h00;
        wdata_o = wdata_i;
        unique case (size_i)
            SzB: begin
                sel_o   = 8'h01 << off_i;
                wdata_o = {8{wdata_i[7:0]}};
            end
            SzH: begin
                sel_o   = 8'h03 << off_i;
                wdata_o = {4{wdata_i[15:0]}};
            end
            SzW: begin
                sel_o   = 8'h0F << off_i;
                wdata_o = {2{wdata_i[31:0]}};
            end
            SzD: begin
                sel_o   = 8'hFF;
                wdata_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_2022040010_lsu_req.sv
// LSU request sequencer: accepts one load/store from EX, issues it to the data
// SRAM, waits for the response (bounded by TIMEOUT) and reports completion.
module ysyx_2022040010_lsu_req
    import ysyx_2022040010_lsu_req_pkg::*;
#(
    parameter int unsigned TIMEOUT = LsuTimeoutDefault
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_2022040010_lsu_req_if.master    bus
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

    lsu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]      sel_q, sel_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [63:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [7:0]      wstrb_q, wstrb_d;
    logic            done_q, done_d;
    logic            mis_q, mis_d;
    logic            berr_q, berr_d;

    lsu_size_e   op_size;
    logic        op_ready;
    logic        accept;
    logic        misaligned;
    logic [7:0]  fmt_sel;
    logic [63:0] fmt_wdata;

    assign op_size    = lsu_size_e'(bus.op_size);
    assign op_ready   = (state_q == StIdle);
    assign accept     = bus.op_valid & op_ready;
    assign misaligned = is_misaligned(op_size, bus.op_addr[2:0]);
    assign cnt_inc    = cnt_q + CntW'(1);

    ysyx_2022040010_lsu_fmt u_fmt (
        .size_i  (op_size),
        .off_i   (bus.op_addr[2:0]),
        .wdata_i (bus.op_wdata),
        .sel_o   (fmt_sel),
        .wdata_o (fmt_wdata)
    );

    // Next-state, captured request fields and one-cycle status pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sel_d = fmt_sel;
                    if (misaligned) begin
                        // Rejected locally; the SRAM never sees it.
                        mis_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = StReq;
                        addr_d  = {bus.op_addr[63:3], 3'b000};
                        we_d    = bus.op_we;
                        wdata_d = fmt_wdata;
                        wstrb_d = bus.op_we ? fmt_sel : 8'h00;
                    end
                end
            end
            StReq: begin
                // A response arriving alongside the handshake belongs to nothing; drop it.
                if (bus.mem_req_ready) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end
            end
            StResp: begin
                if (bus.mem_resp_valid) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutVal) begin
                        berr_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    assign bus.op_ready      = op_ready;
    assign bus.mem_req_valid = (state_q == StReq);
    assign bus.mem_we        = we_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wstrb     = wstrb_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.dsram_sel     = sel_q;
    assign bus.dsram_rdata   = rdata_q;
    assign bus.lsu_done      = done_q;
    assign bus.misalign_err  = mis_q;
    assign bus.bus_err       = berr_q;
    // Stall as soon as an aligned op is taken so EX holds until it completes.
    assign bus.stall_req     = (state_q != StIdle) | (accept & ~misaligned);

endmodule
